// File: rtl/image_loader.sv
// Byte-stream sprite loader: hunts for a sync byte, then packs byte pairs into
// 12-bit RGB pixels and writes them to the image RAM in raster order.
module image_loader #(
    parameter int          IMG_W     = 156,
    parameter int          IMG_H     = 200,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_HI, S_LO} state_t;

    localparam logic [14:0] PITCH  = 15'(IMG_W);
    localparam logic [14:0] LAST_X = 15'(IMG_W - 1);
    localparam logic [14:0] LAST_Y = 15'(IMG_H - 1);

    state_t      state_q, state_d;
    logic [14:0] x_q, x_d;
    logic [14:0] y_q, y_d;
    logic [3:0]  r_q, r_d;
    logic        wr_en_q, wr_en_d;
    logic [14:0] wr_addr_q, wr_addr_d;
    logic [11:0] wr_data_q, wr_data_d;
    logic        done_q, done_d;
    logic        xfer;
    logic [14:0] pix_addr;

    assign xfer     = in_valid && (state_q != S_IDLE);
    assign pix_addr = y_q * PITCH + x_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        r_d       = r_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        // abort outranks start and any byte transfer in the same cycle
        if (abort) begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
            r_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_SYNC;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
                S_SYNC: begin
                    if (xfer && in_data == SYNC_BYTE) state_d = S_HI;
                end
                S_HI: begin
                    if (xfer) begin
                        r_d     = in_data[3:0];
                        state_d = S_LO;
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = pix_addr;
                        wr_data_d = {r_q, in_data};
                        state_d   = S_HI;
                        if (x_q == LAST_X) begin
                            x_d = '0;
                            y_d = y_q + 15'd1;
                            if (y_q == LAST_Y) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                                y_d     = '0;
                            end
                        end else begin
                            x_d = x_q + 15'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            r_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            r_q       <= r_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign in_ready   = (state_q != S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: a 4x2 instance for frame-level scenarios and
// a default-size instance (same stimulus) for the row-pitch check.
module tb_image_loader;

    typedef struct {
        logic [14:0] addr;
        logic [11:0] data;
        logic        done;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;

    logic        a_in_ready, a_wr_en, a_busy, a_frame_done;
    logic [14:0] a_wr_addr;
    logic [11:0] a_wr_data;
    logic        b_in_ready, b_wr_en, b_busy, b_frame_done;
    logic [14:0] b_wr_addr;
    logic [11:0] b_wr_data;

    wr_t qa[$];
    wr_t qb[$];
    bit  mon_a = 1'b1;
    bit  mon_b = 1'b0;
    int  n_cmp = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    image_loader #(.IMG_W(4), .IMG_H(2), .SYNC_BYTE(8'hA5)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .frame_done(a_frame_done)
    );

    image_loader dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    task automatic monitor();
        wr_t e;
        bit  prev_a = 1'b0;
        bit  prev_b = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_a = 1'b0;
                prev_b = 1'b0;
            end else begin
                if (mon_a) begin
                    if (a_wr_en) begin
                        n_cmp++;
                        if (qa.size() == 0) begin
                            n_err++;
                            $display("FAIL a_unexpected_write: got addr=%0d data=%h, required no write", a_wr_addr, a_wr_data);
                        end else begin
                            e = qa.pop_front();
                            if (a_wr_addr !== e.addr || a_wr_data !== e.data || a_frame_done !== e.done) begin
                                n_err++;
                                $display("FAIL a_write: got addr=%0d data=%h done=%b, required addr=%0d data=%h done=%b",
                                         a_wr_addr, a_wr_data, a_frame_done, e.addr, e.data, e.done);
                            end
                        end
                        n_cmp++;
                        if (prev_a !== 1'b0) begin
                            n_err++;
                            $display("FAIL a_wr_en_width: wr_en high two cycles in a row, required one");
                        end
                        if (a_frame_done) begin
                            n_cmp++;
                            if (a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
                                n_err++;
                                $display("FAIL a_done_idle: got busy=%b in_ready=%b, required 0/0", a_busy, a_in_ready);
                            end
                        end
                    end else if (a_frame_done) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL a_done_no_write: frame_done=1 with wr_en=0, required no pulse");
                    end
                end
                if (mon_b && b_wr_en) begin
                    n_cmp++;
                    if (qb.size() == 0) begin
                        n_err++;
                        $display("FAIL b_unexpected_write: got addr=%0d, required no write", b_wr_addr);
                    end else begin
                        e = qb.pop_front();
                        if (b_wr_addr !== e.addr || b_wr_data !== e.data) begin
                            n_err++;
                            $display("FAIL b_write: got addr=%0d data=%h, required addr=%0d data=%h",
                                     b_wr_addr, b_wr_data, e.addr, e.data);
                        end
                    end
                end
                prev_a = a_wr_en;
                prev_b = b_wr_en;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic expect_a(input int addr, input logic [11:0] data, input logic done);
        wr_t e;
        e.addr = 15'(addr);
        e.data = data;
        e.done = done;
        qa.push_back(e);
    endtask

    task automatic check_drained(input string name);
        idle_cycles(3);
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_err++;
            $display("FAIL %s_drained: got %0d/%0d writes outstanding, required 0/0", name, qa.size(), qb.size());
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic send_frame(input bit gaps);
        send_byte(8'hA5);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            send_byte(kb);
            if (gaps) idle_cycles($urandom_range(0, 2));
            expect_a(k, {kb[3:0], 8'h5A}, k == 7);
            send_byte(8'h5A);
            if (gaps) idle_cycles($urandom_range(0, 2));
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({a_in_ready, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0d data=%h busy=%b done=%b, required all 0",
                     a_in_ready, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_frame_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_full_frame();
        pulse_start();
        n_cmp++;
        if (a_busy !== 1'b1 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy: got busy=%b in_ready=%b, required 1/1", a_busy, a_in_ready);
        end
        send_frame(1'b0);
        check_drained("full_frame");
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL frame_end_busy: got %b, required 0", a_busy);
        end
    endtask

    task automatic test_sync_hunt();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'hA5);
        send_byte(8'h0F);
        expect_a(0, 12'hFF0, 1'b0);
        send_byte(8'hF0);
        idle_cycles(2);
        pulse_abort();
        check_drained("sync_hunt");
    endtask

    task automatic test_gaps();
        pulse_start();
        send_frame(1'b1);
        check_drained("gaps");
    endtask

    task automatic test_row_wrap();
        wr_t e;
        pulse_abort();
        mon_a = 1'b0;
        mon_b = 1'b1;
        pulse_start();
        send_byte(8'hA5);
        for (int k = 0; k < 157; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            send_byte(kb);
            e.addr = 15'(k);
            e.data = {kb[3:0], kb ^ 8'h3C};
            e.done = 1'b0;
            qb.push_back(e);
            send_byte(kb ^ 8'h3C);
        end
        idle_cycles(2);
        pulse_abort();
        check_drained("row_wrap");
        mon_a = 1'b1;
        mon_b = 1'b0;
    endtask

    task automatic test_abort();
        pulse_start();
        send_byte(8'hA5);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h07);
            expect_a(k, 12'h7C3, 1'b0);
            send_byte(8'hC3);
        end
        send_byte(8'h02);
        abort    = 1'b1;
        in_data  = 8'h99;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_busy: got %b, required 0", a_busy);
        end
        send_byte(8'h44);
        send_byte(8'h55);
        check_drained("abort");
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h0B);
        expect_a(0, 12'hB12, 1'b0);
        send_byte(8'h12);
        idle_cycles(2);
        pulse_abort();
        check_drained("abort_restart");
    endtask

    task automatic test_async_reset();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h01);
        expect_a(0, 12'h1EE, 1'b0);
        send_byte(8'hEE);
        send_byte(8'h03);
        send_byte(8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_in_ready, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_frame_done} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got rdy=%b we=%b addr=%0d data=%h busy=%b done=%b, required all 0",
                     a_in_ready, a_wr_en, a_wr_addr, a_wr_data, a_busy, a_frame_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA5 + i));
        check_drained("async_reset");
    endtask

    task automatic test_start_while_busy();
        pulse_start();
        send_byte(8'hA5);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            if (k == 1 || k == 5) start = 1'b1;
            send_byte(kb);
            start = 1'b0;
            if (k == 3) pulse_start();
            expect_a(k, {kb[3:0], 8'h5A}, k == 7);
            send_byte(8'h5A);
        end
        check_drained("start_busy");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_full_frame();
        test_sync_hunt();
        test_gaps();
        test_row_wrap();
        test_abort();
        test_async_reset();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
